// File: rtl/ddr3_traffic_gen.sv
// ddr3_traffic_gen: write/read-back traffic generator for a DDR3 command FIFO.
// Writes NUM_BURSTS bursts of BURST_LEN pattern beats, reads them back and counts
// the mismatching beats.
//
// Build option:
//   TGEN_PRBS_EN  when defined, the pattern comes from a 32-bit LFSR.
//                 When undefined, the pattern is the global beat counter.
//
// Ports:
//   clk_25MHz, rstn          clock; asynchronous active-low reset
//   start, calib_complete    run request pulse; DDR3 calibration done
//   fifo_cmd_*               command/write-data channel (valid/ready)
//   fifo_rsp_*               read-data channel (valid/ready)
//   busy, done, pass         run status
//   aborted                  run ended because calibration was lost
//   err_cnt, err_addr        mismatching beats; address of the first failing burst
module ddr3_traffic_gen #(
  parameter int unsigned ADDR_WIDTH  = 27,
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned MASK_WIDTH  = 16,
  parameter int unsigned BRST_WIDTH  = 6,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned NUM_BURSTS  = 4,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned ADDR_STRIDE = 64
) (
  input  logic                  clk_25MHz,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  calib_complete,
  output logic                  fifo_cmd_valid,
  input  logic                  fifo_cmd_ready,
  output logic [1:0]            fifo_cmd_type,
  output logic [ADDR_WIDTH-1:0] fifo_cmd_addr,
  output logic [BRST_WIDTH-1:0] fifo_cmd_burst_cnt,
  output logic [DATA_WIDTH-1:0] fifo_cmd_wt_data,
  output logic [MASK_WIDTH-1:0] fifo_cmd_wt_mask,
  input  logic                  fifo_rsp_valid,
  output logic                  fifo_rsp_ready,
  input  logic [DATA_WIDTH-1:0] fifo_rsp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  aborted,
  output logic [15:0]           err_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr
);

  localparam int unsigned REP    = DATA_WIDTH / 32;
  localparam int unsigned BEAT_W = BRST_WIDTH + 1;
  localparam int unsigned BIDX_W = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_DATA  = 2'd1;
  localparam logic [1:0] CMD_WRITE = 2'd2;
  localparam logic [1:0] CMD_READ  = 2'd3;

`ifdef TGEN_PRBS_EN
  localparam logic [31:0] PAT_SEED = 32'hACE1_0001;
`else
  localparam logic [31:0] PAT_SEED = 32'h0000_0000;
`endif

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_CAL, ST_WR_HDR, ST_WR_DATA, ST_RD_HDR, ST_RD_DATA, ST_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BIDX_W-1:0]     burst_q, burst_d;
  logic [BEAT_W-1:0]     beat_q, beat_d;
  logic [31:0]           pat_q, pat_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic                  aborted_q, aborted_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic [1:0]            cmd_type_q, cmd_type_d;
  logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
  logic [BRST_WIDTH-1:0] cmd_bcnt_q, cmd_bcnt_d;
  logic [DATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
  logic                  rsp_ready_q, rsp_ready_d;

  logic cmd_fire, rsp_fire, last_beat, last_burst, mismatch, cal_lost;

  // Next pattern word: LFSR x^32+x^22+x^2+x+1, or plain counter
  function automatic logic [31:0] pat_next(input logic [31:0] p);
`ifdef TGEN_PRBS_EN
    return {p[30:0], p[31] ^ p[21] ^ p[1] ^ p[0]};
`else
    return p + 32'd1;
`endif
  endfunction

  // Burst address, computed wide then truncated to the FIFO address width
  function automatic logic [ADDR_WIDTH-1:0] burst_addr(input logic [BIDX_W-1:0] idx);
    logic [63:0] a;
    a = 64'(BASE_ADDR) + 64'(idx) * 64'(ADDR_STRIDE);
    return ADDR_WIDTH'(a);
  endfunction

  assign cmd_fire   = cmd_valid_q && fifo_cmd_ready;
  assign rsp_fire   = fifo_rsp_valid && rsp_ready_q;
  assign last_beat  = (beat_q == BEAT_W'(BURST_LEN - 1));
  assign last_burst = (burst_q == BIDX_W'(NUM_BURSTS - 1));
  assign mismatch   = (fifo_rsp_data != {REP{pat_q}});
  // Calibration loss only matters once traffic has started
  assign cal_lost   = !calib_complete &&
                      (state_q inside {ST_WR_HDR, ST_WR_DATA, ST_RD_HDR, ST_RD_DATA});

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    pat_d      = pat_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    aborted_d  = aborted_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_WAIT_CAL;
          burst_d    = '0;
          beat_d     = '0;
          pat_d      = PAT_SEED;
          err_cnt_d  = '0;
          err_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          aborted_d  = 1'b0;
        end
      end
      ST_WAIT_CAL: begin
        if (calib_complete) state_d = ST_WR_HDR;
      end
      ST_WR_HDR: begin
        if (cmd_fire) begin
          state_d = ST_WR_DATA;
          beat_d  = '0;
        end
      end
      ST_WR_DATA: begin
        if (cmd_fire) begin
          pat_d = pat_next(pat_q);
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              // Read phase replays the sequence from the seed
              state_d = ST_RD_HDR;
              burst_d = '0;
              pat_d   = PAT_SEED;
            end else begin
              state_d = ST_WR_HDR;
              burst_d = burst_q + BIDX_W'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      ST_RD_HDR: begin
        if (cmd_fire) begin
          state_d = ST_RD_DATA;
          beat_d  = '0;
        end
      end
      ST_RD_DATA: begin
        if (rsp_fire) begin
          if (mismatch) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
            if (err_cnt_q == 16'd0)    err_addr_d = burst_addr(burst_q);
          end
          pat_d = pat_next(pat_q);
          if (last_beat) begin
            beat_d = '0;
            if (last_burst) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              pass_d  = (err_cnt_q == 16'd0) && !mismatch;
            end else begin
              state_d = ST_RD_HDR;
              burst_d = burst_q + BIDX_W'(1);
            end
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (cal_lost) begin
      state_d   = ST_DONE;
      done_d    = 1'b1;
      busy_d    = 1'b0;
      pass_d    = 1'b0;
      aborted_d = 1'b1;
    end

    // Channel outputs follow the state being entered, so they register cleanly
    cmd_valid_d = (state_d inside {ST_WR_HDR, ST_WR_DATA, ST_RD_HDR});
    cmd_type_d  = CMD_IDLE;
    cmd_addr_d  = '0;
    cmd_bcnt_d  = '0;
    cmd_data_d  = '0;
    rsp_ready_d = (state_d == ST_RD_DATA);
    case (state_d)
      ST_WR_HDR: begin
        cmd_type_d = CMD_WRITE;
        cmd_addr_d = burst_addr(burst_d);
        cmd_bcnt_d = BRST_WIDTH'(BURST_LEN - 1);
      end
      ST_WR_DATA: begin
        cmd_type_d = CMD_DATA;
        cmd_data_d = {REP{pat_d}};
      end
      ST_RD_HDR: begin
        cmd_type_d = CMD_READ;
        cmd_addr_d = burst_addr(burst_d);
        cmd_bcnt_d = BRST_WIDTH'(BURST_LEN - 1);
      end
      default: cmd_type_d = CMD_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_25MHz or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      burst_q     <= '0;
      beat_q      <= '0;
      pat_q       <= '0;
      err_cnt_q   <= '0;
      err_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_IDLE;
      cmd_addr_q  <= '0;
      cmd_bcnt_q  <= '0;
      cmd_data_q  <= '0;
      rsp_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      beat_q      <= beat_d;
      pat_q       <= pat_d;
      err_cnt_q   <= err_cnt_d;
      err_addr_q  <= err_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      aborted_q   <= aborted_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_type_q  <= cmd_type_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_bcnt_q  <= cmd_bcnt_d;
      cmd_data_q  <= cmd_data_d;
      rsp_ready_q <= rsp_ready_d;
    end
  end

  assign fifo_cmd_valid     = cmd_valid_q;
  assign fifo_cmd_type      = cmd_type_q;
  assign fifo_cmd_addr      = cmd_addr_q;
  assign fifo_cmd_burst_cnt = cmd_bcnt_q;
  assign fifo_cmd_wt_data   = cmd_data_q;
  assign fifo_cmd_wt_mask   = '0;
  assign fifo_rsp_ready     = rsp_ready_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign pass               = pass_q;
  assign aborted            = aborted_q;
  assign err_cnt            = err_cnt_q;
  assign err_addr           = err_addr_q;

endmodule
